// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and pipeline control encodings for the MIPS datapath
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} hazard_state_t;
  // Bit order: {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST}
  localparam logic [7:0] CTL_FREEZE = 8'b00000_000;
  localparam logic [7:0] CTL_RUN    = 8'b11111_000;
  localparam logic [7:0] CTL_BRANCH = 8'b11111_110;
  localparam logic [7:0] CTL_LDUSE  = 8'b00111_010;
  localparam logic [7:0] CTL_JUMP   = 8'b11111_100;
  localparam logic [7:0] CTL_IMISS  = 8'b01111_100;
  localparam int CTL_MEMWB = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline stall/flush sequencing with sticky halt
// and saturating stall/flush performance counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memDRE,
  input  logic             memDWE,
  input  logic             memHALT,
  input  logic             exDRE,
  input  regbits_t         exrt,
  input  regbits_t         idrs,
  input  regbits_t         idrt,
  input  logic             exBrTaken,
  input  logic             idJump,
  output logic             pcW,
  output logic             ifidW,
  output logic             idexW,
  output logic             exmemW,
  output logic             memwbW,
  output logic             ifidRST,
  output logic             idexRST,
  output logic             exmemRST,
  output logic             halt,
  output logic [CNT_W-1:0] stallcnt,
  output logic [CNT_W-1:0] flushcnt
);
  hazard_state_t state, state_nx;
  logic [7:0] ctl;
  logic stall_inc, flush_inc, load_use, dmiss;
  assign load_use = exDRE && exrt != '0 && (exrt == idrs || exrt == idrt);
  assign dmiss = (memDRE || memDWE) && !dhit;
  assign {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST} = ctl;
  always_comb begin
    ctl = CTL_FREEZE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_nx = state;
    if (nRST && state != HALTED) begin
      if (dmiss) begin
        state_nx = DWAIT;
        stall_inc = 1'b1;
      end else begin
        state_nx = RUN;
        if (exBrTaken) begin
          ctl = CTL_BRANCH;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ctl = CTL_LDUSE;
          stall_inc = 1'b1;
        end else if (idJump && ihit) begin
          ctl = CTL_JUMP;
          flush_inc = 1'b1;
        end else if (!ihit) begin
          ctl = CTL_IMISS;
          stall_inc = 1'b1;
        end else ctl = CTL_RUN;
        // Halt commits only once the halt instruction actually moves into WB
        if (memHALT && ctl[CTL_MEMWB]) state_nx = HALTED;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= RUN;
      halt <= 1'b0;
    end else begin
      state <= state_nx;
      halt <= state_nx == HALTED;
    end
  sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .nRST(nRST), .inc(stall_inc), .cnt(stallcnt));
  sat_counter #(.W(CNT_W)) u_flush (.CLK(CLK), .nRST(nRST), .inc(flush_inc), .cnt(flushcnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenario tests for hazard_ctrl
module tb_hazard_ctrl;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit = 1'b1, dhit = 1'b1, memDRE = 1'b0, memDWE = 1'b0, memHALT = 1'b0;
  logic exDRE = 1'b0, exBrTaken = 1'b0, idJump = 1'b0;
  regbits_t exrt = '0, idrs = '0, idrt = '0;
  logic pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, halt;
  logic [15:0] stallcnt, flushcnt;
  logic pcW4, ifidW4, idexW4, exmemW4, memwbW4, ifidRST4, idexRST4, exmemRST4, halt4;
  logic [3:0] stallcnt4, flushcnt4;
  logic [7:0] ctl;
  int ncmp = 0, nerr = 0;
  assign ctl = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST};

  hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memDRE(memDRE), .memDWE(memDWE),
    .memHALT(memHALT), .exDRE(exDRE), .exrt(exrt), .idrs(idrs), .idrt(idrt),
    .exBrTaken(exBrTaken), .idJump(idJump), .pcW(pcW), .ifidW(ifidW), .idexW(idexW),
    .exmemW(exmemW), .memwbW(memwbW), .ifidRST(ifidRST), .idexRST(idexRST),
    .exmemRST(exmemRST), .halt(halt), .stallcnt(stallcnt), .flushcnt(flushcnt)
  );
  hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memDRE(memDRE), .memDWE(memDWE),
    .memHALT(memHALT), .exDRE(exDRE), .exrt(exrt), .idrs(idrs), .idrt(idrt),
    .exBrTaken(exBrTaken), .idJump(idJump), .pcW(pcW4), .ifidW(ifidW4), .idexW(idexW4),
    .exmemW(exmemW4), .memwbW(memwbW4), .ifidRST(ifidRST4), .idexRST(idexRST4),
    .exmemRST(exmemRST4), .halt(halt4), .stallcnt(stallcnt4), .flushcnt(flushcnt4)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b1; memDRE = 1'b0; memDWE = 1'b0; memHALT = 1'b0;
    exDRE = 1'b0; exBrTaken = 1'b0; idJump = 1'b0; exrt = '0; idrs = '0; idrt = '0;
  endtask

  task automatic test_reset();
    tick(); tick();
    ncmp++; if (ctl !== 8'h00) begin $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'h00); nerr++; end
    ncmp++; if (halt !== 1'b0) begin $display("FAIL reset_halt got=%b exp=0", halt); nerr++; end
    ncmp++; if (stallcnt !== 16'd0 || flushcnt !== 16'd0) begin
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stallcnt, flushcnt); nerr++; end
    nRST = 1'b1; #1;
    ncmp++; if (ctl !== 8'b11111_000) begin $display("FAIL run_ctl got=%b exp=%b", ctl, 8'b11111_000); nerr++; end
    ihit = 1'b0;
    tick(); tick();
    ncmp++; if (stallcnt !== 16'd2) begin $display("FAIL imiss_cnt got=%0d exp=2", stallcnt); nerr++; end
    nRST = 1'b0; #1;
    ncmp++; if (ctl !== 8'h00 || stallcnt !== 16'd0) begin
      $display("FAIL midrun_reset ctl=%b cnt=%0d exp=00000000/0", ctl, stallcnt); nerr++; end
    ncmp++; if (dut.state !== RUN) begin $display("FAIL reset_state got=%0d exp=%0d", dut.state, RUN); nerr++; end
    ihit = 1'b1;
    tick();
    nRST = 1'b1; #1;
  endtask

  task automatic test_load_use();
    exDRE = 1'b1; exrt = 5'd5; idrs = 5'd5; idrt = 5'd0; #1;
    ncmp++; if (ctl !== 8'b00111_010) begin $display("FAIL lduse_ctl got=%b exp=%b", ctl, 8'b00111_010); nerr++; end
    tick();
    ncmp++; if (stallcnt !== 16'd1) begin $display("FAIL lduse_cnt got=%0d exp=1", stallcnt); nerr++; end
    exDRE = 1'b0; #1;
    ncmp++; if (ctl !== 8'b11111_000) begin $display("FAIL lduse_after got=%b exp=%b", ctl, 8'b11111_000); nerr++; end
    exDRE = 1'b1; exrt = 5'd7; idrs = 5'd3; idrt = 5'd7; #1;
    ncmp++; if (ctl !== 8'b00111_010) begin $display("FAIL lduse_rt got=%b exp=%b", ctl, 8'b00111_010); nerr++; end
    tick();
    exrt = 5'd0; idrs = 5'd0; idrt = 5'd0; #1;
    ncmp++; if (ctl !== 8'b11111_000) begin $display("FAIL lduse_zero got=%b exp=%b", ctl, 8'b11111_000); nerr++; end
    tick();
    ncmp++; if (stallcnt !== 16'd2) begin $display("FAIL lduse_zero_cnt got=%0d exp=2", stallcnt); nerr++; end
    clear_inputs();
  endtask

  task automatic test_data_miss();
    memDRE = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      ncmp++; if (ctl !== 8'h00) begin $display("FAIL dmiss_ctl%0d got=%b exp=00000000", i, ctl); nerr++; end
      tick();
    end
    ncmp++; if (dut.state !== DWAIT) begin $display("FAIL dmiss_state got=%0d exp=%0d", dut.state, DWAIT); nerr++; end
    dhit = 1'b1; #1;
    ncmp++; if (ctl !== 8'b11111_000) begin $display("FAIL dmiss_done got=%b exp=%b", ctl, 8'b11111_000); nerr++; end
    tick();
    ncmp++; if (stallcnt !== 16'd5 || dut.state !== RUN) begin
      $display("FAIL dmiss_cnt cnt=%0d state=%0d exp=5/%0d", stallcnt, dut.state, RUN); nerr++; end
    clear_inputs();
  endtask

  task automatic test_branch();
    exBrTaken = 1'b1; exDRE = 1'b1; exrt = 5'd5; idrs = 5'd5; #1;
    ncmp++; if (ctl !== 8'b11111_110) begin $display("FAIL br_ctl got=%b exp=%b", ctl, 8'b11111_110); nerr++; end
    tick();
    ncmp++; if (flushcnt !== 16'd1 || stallcnt !== 16'd5) begin
      $display("FAIL br_cnt got=%0d/%0d exp=1/5", flushcnt, stallcnt); nerr++; end
    memDWE = 1'b1; dhit = 1'b0; #1;
    ncmp++; if (ctl !== 8'h00) begin $display("FAIL br_miss_ctl got=%b exp=00000000", ctl); nerr++; end
    tick();
    ncmp++; if (stallcnt !== 16'd6 || flushcnt !== 16'd1) begin
      $display("FAIL br_miss_cnt got=%0d/%0d exp=6/1", stallcnt, flushcnt); nerr++; end
    dhit = 1'b1; #1;
    ncmp++; if (ctl !== 8'b11111_110) begin $display("FAIL br_retry got=%b exp=%b", ctl, 8'b11111_110); nerr++; end
    tick();
    ncmp++; if (flushcnt !== 16'd2) begin $display("FAIL br_retry_cnt got=%0d exp=2", flushcnt); nerr++; end
    clear_inputs();
  endtask

  task automatic test_jump();
    idJump = 1'b1; #1;
    ncmp++; if (ctl !== 8'b11111_100) begin $display("FAIL jump_ctl got=%b exp=%b", ctl, 8'b11111_100); nerr++; end
    tick();
    ihit = 1'b0; #1;
    ncmp++; if (ctl !== 8'b01111_100) begin $display("FAIL jump_imiss got=%b exp=%b", ctl, 8'b01111_100); nerr++; end
    tick();
    ncmp++; if (flushcnt !== 16'd3 || stallcnt !== 16'd7) begin
      $display("FAIL jump_cnt got=%0d/%0d exp=3/7", flushcnt, stallcnt); nerr++; end
    clear_inputs();
  endtask

  task automatic test_halt();
    memHALT = 1'b1; memDRE = 1'b1; dhit = 1'b1; #1;
    ncmp++; if (halt !== 1'b0 || ctl !== 8'b11111_000) begin
      $display("FAIL halt_pre halt=%b ctl=%b exp=0/11111000", halt, ctl); nerr++; end
    tick();
    ncmp++; if (halt !== 1'b1 || ctl !== 8'h00) begin
      $display("FAIL halt_set halt=%b ctl=%b exp=1/00000000", halt, ctl); nerr++; end
    clear_inputs();
    ihit = 1'b0; exBrTaken = 1'b1; #1;
    ncmp++; if (ctl !== 8'h00) begin $display("FAIL halt_toggle got=%b exp=00000000", ctl); nerr++; end
    tick(); tick();
    ihit = 1'b1; exBrTaken = 1'b0; memDRE = 1'b1; dhit = 1'b0;
    tick();
    ncmp++; if (halt !== 1'b1 || dut.state !== HALTED) begin
      $display("FAIL halt_sticky halt=%b state=%0d exp=1/%0d", halt, dut.state, HALTED); nerr++; end
    ncmp++; if (stallcnt !== 16'd7 || flushcnt !== 16'd3) begin
      $display("FAIL halt_cnt got=%0d/%0d exp=7/3", stallcnt, flushcnt); nerr++; end
    clear_inputs();
  endtask

  task automatic test_saturation();
    nRST = 1'b0; tick(); nRST = 1'b1; #1;
    ncmp++; if (halt !== 1'b0 || stallcnt4 !== 4'd0) begin
      $display("FAIL sat_reset halt=%b cnt=%0d exp=0/0", halt, stallcnt4); nerr++; end
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    ncmp++; if (stallcnt4 !== 4'd15) begin $display("FAIL sat_cnt4 got=%0d exp=15", stallcnt4); nerr++; end
    ncmp++; if (stallcnt !== 16'd20) begin $display("FAIL sat_cnt16 got=%0d exp=20", stallcnt); nerr++; end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_data_miss();
    test_branch();
    test_jump();
    test_halt();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
